mem_test_result_reporter: RTL and testbench

- Sits directly downstream of the striped-arbiter SRAM memory test.
- Consumes the test's level-style test_done / test_pass outputs and turns each test completion into counted pass/fail results.
- Keeps a sticky failure flag and records the iteration of the first failure.
- Drives the board LED with a distinct pattern for each condition: waiting, all-pass, any-fail. This replaces the raw done-counter LED hookup in the board top.

---
 rtl/mem_test_result_reporter.sv | 73 +++++++
 tb/tb_mem_test_result_reporter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_test_result_reporter.sv
// mem_test_result_reporter: turns memory-test completions into pass/fail counts,
// a sticky first-failure record and a status LED pattern.
module mem_test_result_reporter #(
    parameter int CNT_WIDTH        = 16,
    parameter int PASS_HALF_PERIOD = 6000000,
    parameter int FAIL_HALF_PERIOD = 750000,
    parameter int HALF_W           = 24
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    input  logic                 test_done,
    input  logic                 test_pass,
    output logic                 led,
    output logic                 fail_sticky,
    output logic [CNT_WIDTH-1:0] iter_cnt,
    output logic [CNT_WIDTH-1:0] pass_cnt,
    output logic [CNT_WIDTH-1:0] fail_cnt,
    output logic [CNT_WIDTH-1:0] first_fail_iter,
    output logic                 result_valid
);
    localparam logic [1:0] S_WAIT = 2'd0;
    localparam logic [1:0] S_PASS = 2'd1;
    localparam logic [1:0] S_FAIL = 2'd2;
    localparam logic [HALF_W-1:0] PASS_LAST = HALF_W'(PASS_HALF_PERIOD - 1);
    localparam logic [HALF_W-1:0] FAIL_LAST = HALF_W'(FAIL_HALF_PERIOD - 1);

    logic [1:0]        state, state_nxt;
    logic [HALF_W-1:0] ph;
    logic              done_q, rise, wrap;

    assign rise = test_done & ~done_q;
    // FAIL is absorbing: a failing completion there maps back onto itself
    assign state_nxt = !rise ? state :
                       state == S_WAIT ? (test_pass ? S_PASS : S_FAIL) :
                       !test_pass ? S_FAIL : state;
    assign wrap = ph == (state == S_PASS ? PASS_LAST : FAIL_LAST);

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            done_q          <= 1'b0;
            state           <= S_WAIT;
            ph              <= '0;
            led             <= 1'b1;
            fail_sticky     <= 1'b0;
            iter_cnt        <= '0;
            pass_cnt        <= '0;
            fail_cnt        <= '0;
            first_fail_iter <= '0;
            result_valid    <= 1'b0;
        end else begin
            done_q       <= test_done;
            result_valid <= rise;
            state        <= state_nxt;
            // a new pattern always starts dark for a full half-period
            if (state_nxt != state) begin
                ph  <= '0;
                led <= 1'b0;
            end else if (state != S_WAIT) begin
                ph <= wrap ? '0 : ph + HALF_W'(1);
                if (wrap) led <= ~led;
            end
            if (rise) begin
                if (iter_cnt != '1) iter_cnt <= iter_cnt + CNT_WIDTH'(1);
                if (test_pass && pass_cnt != '1) pass_cnt <= pass_cnt + CNT_WIDTH'(1);
                if (!test_pass && fail_cnt != '1) fail_cnt <= fail_cnt + CNT_WIDTH'(1);
                if (!test_pass && !fail_sticky) begin
                    first_fail_iter <= iter_cnt;
                    fail_sticky     <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_test_result_reporter.sv
// tb_mem_test_result_reporter: randomized and directed stimulus checked by a
// scoreboard against a time-since-entry reference model.
module tb_mem_test_result_reporter;
    localparam int CW = 3;
    localparam int PH = 4;
    localparam int FH = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          rst_n, test_done, test_pass;
    logic          led, fail_sticky, result_valid;
    logic [CW-1:0] iter_cnt, pass_cnt, fail_cnt, first_fail_iter;

    mem_test_result_reporter #(
        .CNT_WIDTH(CW), .PASS_HALF_PERIOD(PH), .FAIL_HALF_PERIOD(FH), .HALF_W(4)
    ) dut (
        .CLK(CLK), .rst_n(rst_n), .test_done(test_done), .test_pass(test_pass),
        .led(led), .fail_sticky(fail_sticky), .iter_cnt(iter_cnt),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .first_fail_iter(first_fail_iter), .result_valid(result_valid)
    );

    always #5 CLK = ~CLK;

    typedef struct { int iter; int pas; int fai; int ffi; } res_t;
    res_t sb[$];

    int checks = 0, failures = 0;
    // model: mode 0=waiting 1=passing 2=failing, t=cycles since entering the mode
    int m_mode = 0, m_t = 0, m_prev = 0, m_led = 1, m_rv = 0;
    int m_iter = 0, m_pass = 0, m_fail = 0, m_ffi = 0, m_sticky = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return v < MAXC ? v + 1 : v;
    endfunction

    task automatic model(input bit d, input bit p, input bit r);
        int nm, half;
        bit rise;
        if (!r) begin
            m_mode = 0; m_t = 0; m_prev = 0; m_led = 1; m_rv = 0;
            m_iter = 0; m_pass = 0; m_fail = 0; m_ffi = 0; m_sticky = 0;
            return;
        end
        rise = d && m_prev == 0;
        m_prev = d;
        m_rv = rise;
        nm = m_mode;
        if (rise && m_mode == 0) nm = p ? 1 : 2;
        else if (rise && m_mode == 1 && !p) nm = 2;
        if (nm != m_mode) begin
            m_mode = nm; m_t = 0; m_led = 0;
        end else if (m_mode != 0) begin
            half = m_mode == 1 ? PH : FH;
            m_t++;
            m_led = (m_t / half) % 2;
        end
        if (rise) begin
            if (!p && !m_sticky) begin m_ffi = m_iter; m_sticky = 1; end
            m_iter = sat(m_iter);
            if (p) m_pass = sat(m_pass); else m_fail = sat(m_fail);
            sb.push_back('{m_iter, m_pass, m_fail, m_ffi});
        end
    endtask

    task automatic step(input bit d, input bit p, input bit r);
        test_done = d; test_pass = p; rst_n = r;
        @(posedge CLK);
        model(d, p, r);
        #1;
    endtask

    task automatic comp(input bit p);
        step(1, p, 1); step(1, p, 1); step(0, 0, 1); step(0, 0, 1);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".iter"}, int'(iter_cnt), m_iter);
        chk({tag, ".pass"}, int'(pass_cnt), m_pass);
        chk({tag, ".fail"}, int'(fail_cnt), m_fail);
        chk({tag, ".ffi"}, int'(first_fail_iter), m_ffi);
        chk({tag, ".sticky"}, int'(fail_sticky), m_sticky);
        chk({tag, ".led"}, int'(led), m_led);
    endtask

    always @(negedge CLK) begin
        res_t r;
        chk("led", int'(led), m_led);
        chk("fail_sticky", int'(fail_sticky), m_sticky);
        chk("result_valid", int'(result_valid), m_rv);
        if (result_valid) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_result_valid: got 1 expected 0 at %0t", $time);
            end else begin
                r = sb.pop_front();
                chk("sb.iter", int'(iter_cnt), r.iter);
                chk("sb.pass", int'(pass_cnt), r.pas);
                chk("sb.fail", int'(fail_cnt), r.fai);
                chk("sb.ffi", int'(first_fail_iter), r.ffi);
            end
        end
    end

    initial begin
        repeat (3) step(0, 0, 0);
        repeat (100) step(0, 0, 1);
        check_all("idle");
        chk("idle.led_on", int'(led), 1);

        repeat (10) step(1, 1, 1);
        repeat (20) step(0, 0, 1);
        chk("single.iter", int'(iter_cnt), 1);
        chk("single.pass", int'(pass_cnt), 1);
        chk("single.fail", int'(fail_cnt), 0);

        step(0, 0, 0);
        repeat (3) comp(1);
        comp(0);
        repeat (2) comp(1);
        repeat (10) step(0, 0, 1);
        check_all("mix");
        chk("mix.iter6", int'(iter_cnt), 6);
        chk("mix.ffi3", int'(first_fail_iter), 3);
        chk("mix.fail1", int'(fail_cnt), 1);

        step(0, 0, 0);
        repeat (10) comp(1);
        chk("sat.iter7", int'(iter_cnt), 7);
        chk("sat.pass7", int'(pass_cnt), 7);
        chk("sat.fail0", int'(fail_cnt), 0);
        comp(0);
        chk("sat.fail1", int'(fail_cnt), 1);
        chk("sat.ffi7", int'(first_fail_iter), 7);

        step(0, 0, 0);
        comp(1);
        while (m_t % PH != PH - 1) step(0, 0, 1);
        step(1, 0, 1);
        chk("wrap.led0", int'(led), 0);
        repeat (6) step(1, 0, 1);
        step(0, 0, 1);
        comp(0);
        chk("rstmid.fail2", int'(fail_cnt), 2);
        step(1, 0, 0);
        check_all("rstmid.reset");
        repeat (5) step(1, 1, 1);
        chk("rstmid.iter1", int'(iter_cnt), 1);
        check_all("rstmid.after");

        for (int i = 0; i < 600; i++) begin
            bit d, p, r;
            d = (test_done && $urandom_range(0, 3) != 0) || (!test_done && $urandom_range(0, 2) == 0);
            p = $urandom_range(0, 5) != 0;
            r = $urandom_range(0, 60) != 0;
            step(d, p, r);
        end
        repeat (3) step(0, 0, 1);
        check_all("random");

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
